instr_fetch_unit: RTL and testbench

- Sequential instruction fetch/issue front end for the 2-bit-opcode microprocessor.
- Owns the PC, fetches 8-bit instructions over a req/ack memory handshake, and issues them with a valid/ready handshake to the control decoder and datapath.
- Consumes branch resolution back from the datapath.
- It is the producer of the opcode stream that the control decoder consumes.

---
 rtl/instr_fetch_unit_pkg.sv | 29 ++
 rtl/instr_fetch_unit_pc_next.sv | 21 ++
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: opcodes, instruction
// field positions and the fetch FSM state encoding.
package instr_fetch_unit_pkg;

    // 2-bit opcode space of the microprocessor
    localparam logic [1:0] OP_RTYPE = 2'd0;
    localparam logic [1:0] OP_LW    = 2'd1;
    localparam logic [1:0] OP_SW    = 2'd2;
    localparam logic [1:0] OP_BEQ   = 2'd3;

    // Instruction fields: op[7:6] rs[5:4] rt[3:2] rd/imm[1:0]
    localparam int OP_HI  = 7;
    localparam int OP_LO  = 6;
    localparam int RS_HI  = 5;
    localparam int RS_LO  = 4;
    localparam int RT_HI  = 3;
    localparam int RT_LO  = 2;
    localparam int IMM_HI = 1;
    localparam int IMM_LO = 0;
    localparam int IMM_W  = IMM_HI - IMM_LO + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        ISSUE   = 2'd2,
        WAIT_BR = 2'd3
    } ifuStateT;

endpackage

// File: rtl/instr_fetch_unit_pc_next.sv
// Next-PC adder: pc+1, or pc+1+sext(imm) for a taken branch. Wraps modulo 2^PC_W.
module ifu_pc_next
    import instr_fetch_unit_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0]  pc,
    input  logic [IMM_W-1:0] imm,
    input  logic             taken,
    output logic [PC_W-1:0]  nextPc
);

    logic [PC_W-1:0] immSext;
    logic [PC_W-1:0] offset;

    // Sign-extend the 2-bit displacement (range -2..+1)
    assign immSext = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign offset  = taken ? (immSext + PC_W'(1)) : PC_W'(1);
    assign nextPc  = pc + offset;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue front end: owns the PC, fetches over a req/ack
// memory port, issues over valid/ready and resolves BEQ from the datapath.
// Optional build macro IFU_PERF_CNT_EN adds saturating busy-cycle and
// retired-instruction counters (cyc_cnt, ret_cnt).
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int          PC_W     = 8,
    parameter int unsigned RESET_PC = 0,
    parameter int          INSTR_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [1:0]         op,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               br_valid,
    input  logic               br_taken,
    output logic [PC_W-1:0]    pc,
    output logic               busy
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [15:0]        cyc_cnt,
    output logic [15:0]        ret_cnt
`endif
);

    ifuStateT        state;
    ifuStateT        stateNext;
    logic [PC_W-1:0] pcNext;
    logic            pcAdvance;
    logic            brTaken;
    logic            fetchDone;
    logic            issueAcc;

    assign op        = instr[OP_HI:OP_LO];
    assign imem_addr = pc;
    assign fetchDone = (state == FETCH) && imem_ack;
    assign issueAcc  = (state == ISSUE) && instr_ready;
    // An instruction retires on a non-BEQ accept or on BEQ resolution
    assign pcAdvance = (issueAcc && (op != OP_BEQ)) || ((state == WAIT_BR) && br_valid);
    assign brTaken   = (state == WAIT_BR) && br_taken;

    ifu_pc_next #(.PC_W(PC_W)) pcNextInst (
        .pc     (pc),
        .imm    (instr[IMM_HI:IMM_LO]),
        .taken  (brTaken),
        .nextPc (pcNext)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    // FSM next-state logic; halt is only looked at when an instruction completes
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (start && !halt) stateNext = FETCH;
            FETCH:   if (imem_ack)       stateNext = ISSUE;
            ISSUE:   if (instr_ready)    stateNext = (op == OP_BEQ) ? WAIT_BR : (halt ? IDLE : FETCH);
            WAIT_BR: if (br_valid)       stateNext = halt ? IDLE : FETCH;
            default:                     stateNext = IDLE;
        endcase
    end

    // FSM outputs are pure functions of the state
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        busy        = 1'b1;
        unique case (state)
            IDLE:    busy        = 1'b0;
            FETCH:   imem_req    = 1'b1;
            ISSUE:   instr_valid = 1'b1;
            WAIT_BR: ;
            default: busy        = 1'b0;
        endcase
    end

    // PC advances only at instruction retirement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         pc <= PC_W'(RESET_PC);
        else if (pcAdvance) pc <= pcNext;
    end

    // Capture the fetched word and its address; held through ISSUE and WAIT_BR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= '0;
            instr_pc <= '0;
        end else if (fetchDone) begin
            instr    <= imem_data;
            instr_pc <= pc;
        end
    end

`ifdef IFU_PERF_CNT_EN
    // Saturating count of busy cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        cyc_cnt <= '0;
        else if (busy && cyc_cnt != 16'hFFFF) cyc_cnt <= cyc_cnt + 16'd1;
    end

    // Saturating count of retired instructions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             ret_cnt <= '0;
        else if (pcAdvance && ret_cnt != 16'hFFFF) ret_cnt <= ret_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a program-walk model predicts the
// issued (pc, instr) stream; responders play memory, decoder and datapath.
module tb_instr_fetch_unit;

    localparam int PW = 8;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          halt = 1'b0;
    logic          imem_ack = 1'b0;
    logic [IW-1:0] imem_data = '0;
    logic          instr_ready = 1'b0;
    logic          br_valid = 1'b0;
    logic          br_taken = 1'b0;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          instr_valid;
    logic [IW-1:0] instr;
    logic [1:0]    op;
    logic [PW-1:0] instr_pc;
    logic [PW-1:0] pc;
    logic          busy;
`ifdef IFU_PERF_CNT_EN
    logic [15:0]   cyc_cnt;
    logic [15:0]   ret_cnt;
`endif

    instr_fetch_unit #(.PC_W(PW), .RESET_PC(0), .INSTR_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .op(op),
        .instr_pc(instr_pc), .br_valid(br_valid), .br_taken(br_taken), .pc(pc), .busy(busy)
`ifdef IFU_PERF_CNT_EN
        , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] pc; logic [7:0] ins; } expT;

    int         total = 0;
    int         bad = 0;
    expT        expQ[$];
    bit         brOut[$];
    bit         brPlan[$];
    logic [7:0] mem [256];
    logic [7:0] modelPc = 8'h00;
    int minAck = 0, maxAck = 0, minRdy = 0, maxRdy = 0, minBr = 0, maxBr = 0;
    int nIssue = 0, issued = 0, haltMode = 0, haltAt = 0;
    int ackWait = -1, rdyWait = -1, brWait = 0;
    bit envOn = 0, startEn = 0, ackHold = 0, brNoise = 0;
    bit brPend = 0, lastAcc = 0, lastAccBeq = 0, lastBr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Walk the program: each executed instruction is issued from its address;
    // BEQ moves to pc+1+imm when taken, everything else to pc+1, modulo 256.
    task automatic buildModel(input int n);
        logic [7:0] p;
        logic [7:0] w;
        int         off;
        bit         t;
        expT        e;
        p = modelPc;
        for (int i = 0; i < n; i++) begin
            w = mem[p];
            e.pc = p;
            e.ins = w;
            expQ.push_back(e);
            off = 1;
            if (w[7:6] == 2'd3) begin
                t = (brPlan.size() != 0) ? brPlan.pop_front() : 1'($urandom_range(1, 0));
                brOut.push_back(t);
                if (t) off = w[1] ? int'(w[1:0]) - 3 : int'(w[1:0]) + 1;
            end
            p = p + 8'(off);
        end
        modelPc = p;
    endtask

    // Environment responders: memory, decoder ready, branch resolution, start/halt
    always @(posedge clk) begin
        #1;
        if (lastAcc) begin
            issued++;
            if (lastAccBeq) begin brPend = 1; brWait = $urandom_range(maxBr, minBr); end
        end
        if (lastBr) brPend = 0;
        lastAcc = 0; lastAccBeq = 0; lastBr = 0;
        if (!envOn) begin
            imem_ack = 0; instr_ready = 0; br_valid = 0;
        end else begin
            if (imem_req && !ackHold) begin
                if (ackWait < 0) ackWait = $urandom_range(maxAck, minAck);
                if (ackWait == 0) begin imem_ack = 1; imem_data = mem[imem_addr]; ackWait = -1; end
                else begin imem_ack = 0; imem_data = 8'($urandom); ackWait--; end
            end else begin
                imem_ack = 0; ackWait = -1;
            end
            if (instr_valid && issued < nIssue) begin
                if (rdyWait < 0) rdyWait = $urandom_range(maxRdy, minRdy);
                if (rdyWait == 0) begin
                    instr_ready = 1; lastAcc = 1; lastAccBeq = (op == 2'd3); rdyWait = -1;
                end else begin
                    instr_ready = 0; rdyWait--;
                end
            end else begin
                instr_ready = 0; rdyWait = -1;
            end
            if (brPend) begin
                if (brWait == 0) begin
                    br_valid = 1; br_taken = (brOut.size() != 0) ? brOut.pop_front() : 1'b0; lastBr = 1;
                end else begin
                    br_valid = 0; brWait--;
                end
            end else begin
                br_valid = brNoise && ($urandom_range(3, 0) == 0);
                br_taken = 1'($urandom);
            end
        end
        case (haltMode)
            1:       halt = ($urandom_range(7, 0) == 0);
            2:       halt = (issued > haltAt) || (issued == haltAt && instr_valid);
            default: halt = 0;
        endcase
        start = startEn;
    end

    // Monitor: pops the scoreboard on every issue handshake and checks stability
    expT        me;
    bit         inFetch = 0;
    bit         prevHold = 0;
    logic [7:0] fAddr, hIns, hPc;
    always @(negedge clk) begin
        if (!rst_n) begin
            inFetch = 0; prevHold = 0;
        end else begin
            if (imem_req) begin
                if (inFetch) chk("imem_addr_hold", imem_addr, fAddr);
                else begin inFetch = 1; fAddr = imem_addr; end
                if (imem_ack) inFetch = 0;
            end else inFetch = 0;
            if (prevHold) begin
                chk("valid_hold", instr_valid, 1);
                chk("instr_hold", instr, hIns);
                chk("instr_pc_hold", instr_pc, hPc);
            end
            if (instr_valid && instr_ready) begin
                if (expQ.size() == 0) chk("unexpected_issue", expQ.size(), 1);
                else begin
                    me = expQ.pop_front();
                    chk("issue_pc", instr_pc, me.pc);
                    chk("issue_instr", instr, me.ins);
                    chk("issue_op", op, me.ins[7:6]);
                    chk("pc_at_issue", pc, me.pc);
                end
            end
            prevHold = instr_valid && !instr_ready;
            hIns = instr;
            hPc = instr_pc;
        end
    end

    task automatic doReset;
        envOn = 0; startEn = 0; ackHold = 0; brNoise = 0; haltMode = 0;
        rst_n = 0; start = 0; halt = 0;
        expQ.delete(); brOut.delete(); brPlan.delete();
        brPend = 0; lastAcc = 0; lastAccBeq = 0; lastBr = 0; issued = 0; nIssue = 0;
        ackWait = -1; rdyWait = -1; modelPc = 8'h00;
        minAck = 0; maxAck = 0; minRdy = 0; maxRdy = 0; minBr = 0; maxBr = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        @(negedge clk);
    endtask

    task automatic runProg(input int n, input int hAt, input int limit);
        int cyc;
        issued = 0; nIssue = n; haltAt = hAt;
        buildModel(n);
        envOn = 1; startEn = 1;
        cyc = 0;
        while (!(issued >= nIssue && !lastAcc && !brPend && !lastBr && expQ.size() == 0) && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= limit) chk("drain_timeout", expQ.size(), 0);
        if (haltMode == 2) begin
            cyc = 0;
            while (busy && cyc < 20) begin @(negedge clk); cyc++; end
            chk("idle_after_halt", busy, 0);
            chk("final_pc", pc, modelPc);
            repeat (3) begin @(negedge clk); chk("no_req_when_idle", imem_req, 0); end
        end
    endtask

    task automatic fillPlain(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) mem[i] = {2'($urandom_range(2, 0)), 6'($urandom)};
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        @(negedge clk);
        chk("rst_state_busy", busy, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        doReset;

        // First instruction, zero-wait ack/ready, then halt
        mem[0] = 8'h1B;
        fillPlain(1, 8'h0F);
        haltMode = 2;
        runProg(1, 0, 100);

        // Slow memory (3 wait cycles) and stalled decoder (2 cycles), pc 1..6
        minAck = 3; maxAck = 3; minRdy = 2; maxRdy = 2;
        runProg(6, 5, 400);

        // BEQ at 0x10 with imm=-2: taken then not taken
        minAck = 0; maxAck = 0; minRdy = 0; maxRdy = 0; maxBr = 2;
        mem[8'h10] = 8'hC2;
        fillPlain(8'h11, 8'h11);
        brPlan = '{1'b1, 1'b0};
        runProg(13, 12, 400);

        // Halt during ISSUE of a BEQ at 0x12, resolved 2 cycles later, taken +1
        mem[8'h12] = 8'hC1;
        minBr = 2; maxBr = 2;
        brPlan = '{1'b1};
        runProg(1, 0, 100);

        // Wrap cases: BEQ 0 -> 0xFF, then plain 0xFF -> 0x00 / BEQ +1 at 0xFF -> 0x01
        doReset;
        haltMode = 2;
        mem[8'h00] = 8'hC2; mem[8'hFF] = 8'h40;
        brPlan = '{1'b1};
        runProg(2, 1, 100);
        mem[8'hFF] = 8'hC1;
        brPlan = '{1'b1, 1'b1};
        runProg(2, 1, 100);

        // Four plain instructions back to back from reset
        doReset;
        haltMode = 2;
        fillPlain(0, 3);
        runProg(4, 3, 100);
`ifdef IFU_PERF_CNT_EN
        chk("ret_cnt", ret_cnt, 4);
        chk("cyc_cnt", cyc_cnt, 8);
`endif

        // Async reset in the middle of a fetch, then a stray ack after reset
        ackHold = 1; haltMode = 0;
        repeat (3) @(negedge clk);
        chk("midfetch_req", imem_req, 1);
        chk("midfetch_addr", imem_addr, 4);
        #2 rst_n = 0;
        #1;
        chk("async_rst_req", imem_req, 0);
        chk("async_rst_pc", pc, 0);
        chk("async_rst_busy", busy, 0);
        envOn = 0; startEn = 0; ackHold = 0;
        @(negedge clk);
        rst_n = 1; imem_ack = 1; imem_data = 8'hC3;
        @(negedge clk);
        chk("stray_ack_req", imem_req, 0);
        chk("stray_ack_valid", instr_valid, 0);
        chk("stray_ack_instr", instr, 0);

        // Randomized program with random delays, halts and stray br_valid
        doReset;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        haltMode = 1; brNoise = 1;
        maxAck = 3; maxRdy = 2; maxBr = 3;
        runProg(300, 0, 6000);
        repeat (3) @(negedge clk);
        chk("final_pc_random", pc, modelPc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
